// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-request arbiter family: FSM state
// encoding and default widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWNED = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_t;

    localparam int unsigned MEM_ARB_N_REQ     = 4;
    localparam int unsigned MEM_ARB_ID_W      = 2;
    localparam int unsigned MEM_ARB_TIMEOUT_W = 8;

endpackage : mem_arb_pkg

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: searches upward from i_ptr+1, wrapping
// modulo N_REQ, and returns the first requesting index.
module mem_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_win_onehot_c,
    output logic [ID_W-1:0]  o_win_id_c,
    output logic             o_any_c
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Index of the requester 'off' positions after 'base', modulo N_REQ.
    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned off);
        return (base + off) % N_REQ;
    endfunction

    // Rotate-and-priority-encode; first hit after the pointer wins.
    always_comb begin
        o_win_onehot_c = '0;
        o_win_id_c     = '0;
        o_any_c        = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            if (!o_any_c && i_req[IDX_W'(rr_index(32'(i_ptr), k))]) begin
                o_any_c = 1'b1;
                o_win_onehot_c[IDX_W'(rr_index(32'(i_ptr), k))] = 1'b1;
                o_win_id_c = ID_W'(rr_index(32'(i_ptr), k));
            end
        end
    end

endmodule : mem_rr_pick

// File: rtl/mem_req_arbiter.sv
// Round-robin owner arbiter for the shared memory transaction path.
// One owner at a time, a single idle GAP cycle between owners so chip-select
// can deassert. Optional ownership watchdog: define MEM_ARB_WATCHDOG_EN.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = MEM_ARB_N_REQ,
    parameter int unsigned ID_W      = MEM_ARB_ID_W,
    parameter int unsigned TIMEOUT_W = MEM_ARB_TIMEOUT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     in_req,
    input  logic [N_REQ-1:0]     in_release,
    input  logic [TIMEOUT_W-1:0] in_timeout_limit,
    output logic [N_REQ-1:0]     out_grant,
    output logic                 out_grant_valid,
    output logic [ID_W-1:0]      out_grant_id,
    output logic                 out_busy,
    output logic                 out_timeout
);

    arb_state_t       r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [N_REQ-1:0] r_grant;
    logic [ID_W-1:0]  r_grant_id;
    logic             r_grant_valid;
    logic             r_busy;

    logic [N_REQ-1:0] w_win_onehot;
    logic [ID_W-1:0]  w_win_id;
    logic             w_any;
    logic             w_owner_done;
    logic             w_wd_expire;

    mem_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .i_req          (in_req),
        .i_ptr          (r_ptr),
        .o_win_onehot_c (w_win_onehot),
        .o_win_id_c     (w_win_id),
        .o_any_c        (w_any)
    );

    // Owner leaves on its release pulse, by dropping its request, or on watchdog.
    assign w_owner_done = (|(r_grant & in_release)) || !(|(r_grant & in_req)) || w_wd_expire;

`ifdef MEM_ARB_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] r_wd_cnt;
    logic [TIMEOUT_W-1:0] w_wd_cnt_inc;
    logic                 r_timeout;

    // w_wd_cnt_inc is the number of OWNED cycles including the current one.
    assign w_wd_cnt_inc = (r_wd_cnt == '1) ? r_wd_cnt : r_wd_cnt + TIMEOUT_W'(1);
    assign w_wd_expire  = (r_state == ARB_OWNED) && (in_timeout_limit != '0)
                          && (w_wd_cnt_inc == in_timeout_limit);

    // Ownership watchdog counter and sticky revoke flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ARB_OWNED) begin
                r_wd_cnt <= w_wd_cnt_inc;
            end else begin
                r_wd_cnt <= '0;
            end
            if (w_wd_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign out_timeout = r_timeout;
`else
    logic w_unused_limit;

    assign w_unused_limit = |in_timeout_limit;
    assign w_wd_expire    = 1'b0;
    assign out_timeout    = 1'b0;
`endif

    // Arbitration FSM with registered grant outputs and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ARB_IDLE;
            r_ptr         <= ID_W'(N_REQ - 1);
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_state       <= ARB_OWNED;
                        r_ptr         <= w_win_id;
                        r_grant       <= w_win_onehot;
                        r_grant_id    <= w_win_id;
                        r_grant_valid <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                ARB_OWNED: begin
                    if (w_owner_done) begin
                        r_state       <= ARB_GAP;
                        r_grant       <= '0;
                        r_grant_id    <= '0;
                        r_grant_valid <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                ARB_GAP: begin
                    r_state <= ARB_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state       <= ARB_IDLE;
                    r_grant       <= '0;
                    r_grant_id    <= '0;
                    r_grant_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    // Grant must never have more than one bit set.
    assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));

    assign out_grant       = r_grant;
    assign out_grant_id    = r_grant_id;
    assign out_grant_valid = r_grant_valid;
    assign out_busy        = r_busy;

endmodule : mem_req_arbiter

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed vector table, watchdog
// sequence and randomized traffic against a behavioural reference model.
module tb_mem_req_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TW = 8;
`ifdef MEM_ARB_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [N-1:0]  in_req;
    logic [N-1:0]  in_release;
    logic [TW-1:0] in_timeout_limit;
    logic [N-1:0]  out_grant;
    logic          out_grant_valid;
    logic [IW-1:0] out_grant_id;
    logic          out_busy;
    logic          out_timeout;

    int n_cmp = 0;
    int n_err = 0;

    mem_req_arbiter #(.N_REQ(N), .ID_W(IW), .TIMEOUT_W(TW)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_req           (in_req),
        .in_release       (in_release),
        .in_timeout_limit (in_timeout_limit),
        .out_grant        (out_grant),
        .out_grant_valid  (out_grant_valid),
        .out_grant_id     (out_grant_id),
        .out_busy         (out_busy),
        .out_timeout      (out_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: current owner (-1 none), pending gap, last winner,
    // cycles owned so far, sticky timeout.
    int m_owner = -1;
    int m_gap   = 0;
    int m_last  = N - 1;
    int m_held  = 0;
    int m_tmo   = 0;

    task automatic model_edge();
        bit expire;
        if (rst) begin
            m_owner = -1; m_gap = 0; m_last = N - 1; m_held = 0; m_tmo = 0;
        end else if (m_owner >= 0) begin
            expire = WD_EN && (in_timeout_limit != 0) && (m_held == int'(in_timeout_limit));
            if (in_release[m_owner] || !in_req[m_owner] || expire) begin
                if (expire) m_tmo = 1;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held = (m_held + 1 > 255) ? 255 : m_held + 1;
            end
        end else if (m_gap != 0) begin
            m_gap = 0;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && in_req[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_held  = 1;
                end
            end
        end
    endtask

    // One clock: advance the model at the edge, settle, return.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_out(input string name, input logic [N-1:0] eg, input logic [IW-1:0] eid,
                             input logic ebusy, input logic etmo);
        n_cmp++;
        if (out_grant !== eg || out_grant_id !== eid || out_grant_valid !== (|eg) ||
            out_busy !== ebusy || out_timeout !== etmo) begin
            n_err++;
            $display("FAIL %s: got grant=%b id=%0d valid=%b busy=%b tmo=%b, want grant=%b id=%0d valid=%b busy=%b tmo=%b",
                     name, out_grant, out_grant_id, out_grant_valid, out_busy, out_timeout,
                     eg, eid, |eg, ebusy, etmo);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_model(input string name);
        logic [N-1:0]  eg;
        logic [IW-1:0] eid;
        eg  = '0;
        eid = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            eid = IW'(m_owner);
        end
        check_out(name, eg, eid, (m_owner >= 0) || (m_gap != 0), m_tmo != 0);
    endtask

    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic [N-1:0]  rel;
        logic [N-1:0]  grant;
        logic [IW-1:0] id;
        logic          busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [N-1:0] q, logic [N-1:0] l,
                                logic [N-1:0] g, logic [IW-1:0] i, logic b);
        vec_t v;
        v.rst = r; v.req = q; v.rel = l; v.grant = g; v.id = i; v.busy = b;
        return v;
    endfunction

    initial begin
        int hi;
        int low;
        bit dropped;
        logic [N-1:0] rq;

        rst = 1'b1; in_req = '0; in_release = '0; in_timeout_limit = '0;

        // Inputs applied before an edge, outputs expected just after it.
        // Full round of four requesters.
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 0, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b0001, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b0010, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100, 2, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b0100, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b1000, 3, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b1000, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        // Owner 2, non-owner release ignored, then owner release.
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 1));
        vecs.push_back(mk(0, 4'b0101, 4'b0000, 4'b0100, 2, 1));
        vecs.push_back(mk(0, 4'b0101, 4'b0001, 4'b0100, 2, 1));
        vecs.push_back(mk(0, 4'b0101, 4'b0100, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        // Single requester re-granted with one gap cycle each time.
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        // Owner 3 abandons by dropping its request.
        vecs.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 3, 1));
        vecs.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 3, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        // Reset during ownership, then pointer restarts at requester 0.
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 1));
        vecs.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0110, 4'b0000, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst        = vecs[i].rst;
            in_req     = vecs[i].req;
            in_release = vecs[i].rel;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].id, vecs[i].busy, 1'b0);
        end

        // Watchdog: owner 0 never releases, limit 5.
        rst = 1'b0; in_release = '0; in_timeout_limit = 8'd5; in_req = 4'b0001;
        step();
        check_out("wd_first_grant", 4'b0001, 0, 1'b1, 1'b0);
        hi = 1;
        dropped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!dropped) begin
                step();
                if (out_grant == 4'b0001) hi++;
                else dropped = 1'b1;
            end
        end
        check_int("wd_owned_cycles", hi, WD_EN ? 5 : 21);
        check_int("wd_timeout_flag", int'(out_timeout), WD_EN ? 1 : 0);

        // Limit 0 disables the watchdog entirely.
        in_timeout_limit = '0;
        low = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (out_grant != 4'b0001) low++;
        end
        check_int("wd_disabled_low_cycles", low, WD_EN ? 1 : 0);
        check_int("wd_timeout_sticky", int'(out_timeout), WD_EN ? 1 : 0);
        in_req = '0;
        step();
        step();
        check_model("wd_tail");

        // Randomized traffic against the reference model.
        rq = '0;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 200) == 0) begin
                case ($urandom_range(0, 3))
                    0: in_timeout_limit = 8'd0;
                    1: in_timeout_limit = 8'd1;
                    2: in_timeout_limit = 8'd3;
                    default: in_timeout_limit = 8'd7;
                endcase
            end
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) rq[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 9) == 0) rq[$urandom_range(0, N - 1)] = 1'b0;
            in_req = rq;
            in_release = '0;
            if ($urandom_range(0, 5) == 0) in_release[$urandom_range(0, N - 1)] = 1'b1;
            if (m_owner >= 0 && $urandom_range(0, 3) == 0) in_release[m_owner] = 1'b1;
            step();
            check_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem_req_arbiter
